// File: rtl/fan_pkg.sv
// Shared fan-control definitions: speed encodings and default PWM/duty constants.
// Also consumed by the speed-select FSM and the display logic.
package fan_pkg;

    typedef enum logic [1:0] {
        SPD_OFF  = 2'd0,
        SPD_LOW  = 2'd1,
        SPD_MID  = 2'd2,
        SPD_HIGH = 2'd3
    } speed_e;

    localparam int FAN_CNT_W     = 7;
    localparam int FAN_PERIOD    = 100;
    localparam int FAN_DUTY_LOW  = 30;
    localparam int FAN_DUTY_MID  = 60;
    localparam int FAN_DUTY_HIGH = 100;
    localparam int FAN_RAMP_STEP = 10;

endpackage

// File: rtl/fan_pwm_generator_if.sv
// Control/drive bundle between the speed-select side and the fan PWM generator.
// master = upstream driver of divided clock/speed/stop, slave = the generator.
interface fan_pwm_generator_if #(
    parameter int CNT_W = 7
);
    logic             i_div_clk;
    logic [1:0]       i_speed;
    logic             i_stop;
    logic             o_pwm;
    logic [CNT_W-1:0] o_duty;
    logic             o_period_end;
    logic             o_at_target;

    modport master (
        output i_div_clk, i_speed, i_stop,
        input  o_pwm, o_duty, o_period_end, o_at_target
    );

    modport slave (
        input  i_div_clk, i_speed, i_stop,
        output o_pwm, o_duty, o_period_end, o_at_target
    );
endinterface

// File: rtl/fan_tick_edge.sv
// Rising-edge detector for a signal already synchronous to i_clk.
// Emits a one-cycle pulse on each 0->1 transition; also used for button edges.
module fan_tick_edge (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_sig,
    output logic o_pulse
);

    logic sig_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= i_sig;
        end
    end

    assign o_pulse = i_sig & ~sig_q;

endmodule

// File: rtl/fan_pwm_generator.sv
// Fan motor PWM generator: period counter on divided-clock ticks, per-period
// soft ramp of the applied duty toward the speed target, registered PWM compare.
module fan_pwm_generator
    import fan_pkg::*;
#(
    parameter int CNT_W     = FAN_CNT_W,
    parameter int PERIOD    = FAN_PERIOD,
    parameter int DUTY_LOW  = FAN_DUTY_LOW,
    parameter int DUTY_MID  = FAN_DUTY_MID,
    parameter int DUTY_HIGH = FAN_DUTY_HIGH,
    parameter int RAMP_STEP = FAN_RAMP_STEP
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    fan_pwm_generator_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W:0]   STEP_X   = (CNT_W + 1)'(RAMP_STEP);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             period_end_q, period_end_d;
    logic             tick;
    logic             wrap;
    logic [CNT_W-1:0] target;

    function automatic logic [CNT_W-1:0] target_of(input speed_e s);
        logic [CNT_W-1:0] t;
        case (s)
            SPD_LOW:  t = CNT_W'(DUTY_LOW);
            SPD_MID:  t = CNT_W'(DUTY_MID);
            SPD_HIGH: t = CNT_W'(DUTY_HIGH);
            default:  t = '0;
        endcase
        return t;
    endfunction

    // One extra bit keeps cur+STEP and tgt+STEP from wrapping, so the clamp
    // comparisons stay exact and the result lands on the target, never past it.
    function automatic logic [CNT_W-1:0] ramp_toward(input logic [CNT_W-1:0] cur,
                                                     input logic [CNT_W-1:0] tgt);
        logic [CNT_W:0] cur_x;
        logic [CNT_W:0] tgt_x;
        logic [CNT_W:0] up_x;
        logic [CNT_W-1:0] res;
        cur_x = {1'b0, cur};
        tgt_x = {1'b0, tgt};
        up_x  = cur_x + STEP_X;
        res   = cur;
        if (cur < tgt) begin
            res = (up_x >= tgt_x) ? tgt : up_x[CNT_W-1:0];
        end else if (cur > tgt) begin
            res = (cur_x <= tgt_x + STEP_X) ? tgt : CNT_W'(cur_x - STEP_X);
        end
        return res;
    endfunction

    fan_tick_edge u_tick_edge (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_sig     (bus.i_div_clk),
        .o_pulse   (tick)
    );

    assign target = target_of(speed_e'(bus.i_speed));
    assign wrap   = tick & (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d        = cnt_q;
        duty_d       = duty_q;
        period_end_d = 1'b0;
        pwm_d        = (cnt_q < duty_q);
        // Stop overrides everything, including a wrap in the same cycle.
        if (bus.i_stop) begin
            cnt_d  = '0;
            duty_d = '0;
            pwm_d  = 1'b0;
        end else if (tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            if (wrap) begin
                period_end_d = 1'b1;
                duty_d       = ramp_toward(duty_q, target);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q        <= '0;
            duty_q       <= '0;
            pwm_q        <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            duty_q       <= duty_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
        end
    end

    assign bus.o_pwm        = pwm_q;
    assign bus.o_duty       = duty_q;
    assign bus.o_period_end = period_end_q;
    assign bus.o_at_target  = (duty_q == target);

endmodule

// File: tb/tb_fan_pwm_generator.sv
// Directed bench for fan_pwm_generator: default instance plus a RAMP_STEP=25
// instance for the overshoot clamp; divided clock runs at one rising edge per 4 cycles.
module tb_fan_pwm_generator;
    import fan_pkg::*;

    localparam int TICK_CYC = 4;
    localparam int PER_CYC  = 100 * TICK_CYC;

    logic clk = 1'b0;
    logic rst_n;
    logic div = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_CYC / 2) @(posedge clk);
            #1 div = ~div;
        end
    end

    fan_pwm_generator_if #(.CNT_W(7)) u_bus ();
    fan_pwm_generator_if #(.CNT_W(7)) u_bus2 ();

    assign u_bus.i_div_clk  = div;
    assign u_bus2.i_div_clk = div;
    assign u_bus2.i_stop    = 1'b0;
    assign u_bus2.i_speed   = SPD_LOW;

    fan_pwm_generator dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (u_bus.slave)
    );

    fan_pwm_generator #(.RAMP_STEP(25)) dut2 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (u_bus2.slave)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!u_bus.o_period_end && n < 2 * PER_CYC);
        if (!u_bus.o_period_end) check("period_end_timeout", 0, 1);
    endtask

    // Counts PWM-high cycles over one full period; ends on the next pulse cycle.
    task automatic measure_high(input string tag, input int exp_hi);
        int hi;
        hi = 0;
        repeat (PER_CYC) begin
            @(negedge clk);
            if (u_bus.o_pwm) hi++;
        end
        check(tag, hi, exp_hi);
        check({tag, "_pe"}, int'(u_bus.o_period_end), 1);
    endtask

    task automatic do_reset(input logic [1:0] spd);
        @(negedge clk);
        rst_n = 1'b0;
        u_bus.i_speed = spd;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int e2;
        rst_n         = 1'b0;
        u_bus.i_speed = SPD_OFF;
        u_bus.i_stop  = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_pwm", int'(u_bus.o_pwm), 0);
        check("rst_duty", int'(u_bus.o_duty), 0);
        check("rst_pe", int'(u_bus.o_period_end), 0);
        check("rst_duty2", int'(u_bus2.o_duty), 0);
        rst_n = 1'b1;

        // Speed off: duty stays 0, pulses every period.
        wait_pe(n);
        check("off_duty", int'(u_bus.o_duty), 0);
        check("off_at_target", int'(u_bus.o_at_target), 1);
        wait_pe(n);
        check("off_period_len", n, PER_CYC);
        measure_high("off_high", 0);

        // Speed mid from reset; the STEP=25 instance clamps at 30.
        do_reset(SPD_MID);
        for (int k = 1; k <= 6; k++) begin
            wait_pe(n);
            check($sformatf("mid_duty_%0d", k), int'(u_bus.o_duty), 10 * k);
            check($sformatf("mid_at_tgt_%0d", k), int'(u_bus.o_at_target), (k == 6) ? 1 : 0);
            e2 = 25 * k;
            if (e2 > 30) e2 = 30;
            check($sformatf("step25_duty_%0d", k), int'(u_bus2.o_duty), e2);
        end
        check("step25_at_tgt", int'(u_bus2.o_at_target), 1);
        measure_high("mid_high", 240);
        check("mid_hold", int'(u_bus.o_duty), 60);

        // Up to full duty, then ramp down to off.
        u_bus.i_speed = SPD_HIGH;
        for (int k = 1; k <= 4; k++) begin
            wait_pe(n);
            check($sformatf("high_duty_%0d", k), int'(u_bus.o_duty), 60 + 10 * k);
        end
        measure_high("full_high", PER_CYC);
        u_bus.i_speed = SPD_OFF;
        for (int k = 1; k <= 10; k++) begin
            wait_pe(n);
            check($sformatf("down_duty_%0d", k), int'(u_bus.o_duty), 100 - 10 * k);
        end
        measure_high("zero_high", 0);

        // Stop mid-period at duty 60.
        u_bus.i_speed = SPD_MID;
        for (int k = 1; k <= 6; k++) wait_pe(n);
        check("pre_stop_duty", int'(u_bus.o_duty), 60);
        repeat (150) @(negedge clk);
        check("pre_stop_pwm", int'(u_bus.o_pwm), 1);
        @(posedge clk);
        #1 u_bus.i_stop = 1'b1;
        @(posedge clk);
        #1 u_bus.i_stop = 1'b0;
        @(negedge clk);
        check("stop_pwm", int'(u_bus.o_pwm), 0);
        check("stop_duty", int'(u_bus.o_duty), 0);
        wait_pe(n);
        check("stop_restart_len", int'(n >= PER_CYC - 4 && n <= PER_CYC + 4), 1);
        check("stop_restart_duty", int'(u_bus.o_duty), 10);

        // Stop asserted exactly on the wrap cycle suppresses the pulse.
        repeat (PER_CYC - 1) @(posedge clk);
        #1 u_bus.i_stop = 1'b1;
        @(posedge clk);
        #1 u_bus.i_stop = 1'b0;
        @(negedge clk);
        check("stop_wrap_pe", int'(u_bus.o_period_end), 0);
        check("stop_wrap_duty", int'(u_bus.o_duty), 0);
        wait_pe(n);
        check("stop_wrap_restart", int'(u_bus.o_duty), 10);

        // Asynchronous reset between clock edges, mid-ramp.
        wait_pe(n);
        check("pre_rst_duty", int'(u_bus.o_duty), 20);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_duty", int'(u_bus.o_duty), 0);
        check("async_pwm", int'(u_bus.o_pwm), 0);
        check("async_duty2", int'(u_bus2.o_duty), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_pe(n);
        check("post_rst_len", int'(n >= PER_CYC - 4 && n <= PER_CYC + 4), 1);
        check("post_rst_duty", int'(u_bus.o_duty), 10);
        check("post_rst_at_tgt", int'(u_bus.o_at_target), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
